// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for the register bank's single write port.
// Define REGARB_FIXED_PRIO_EN to make port B win every tie (no round-robin pointer).
module regfile_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     a_valid,
   input  logic [ADDR_W-1:0]        a_addr,
   input  logic [DATA_W-1:0]        a_data,
   output logic                     a_ready,
   input  logic                     b_valid,
   input  logic [ADDR_W-1:0]        b_addr,
   input  logic [DATA_W-1:0]        b_data,
   output logic                     b_ready,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [(1<<ADDR_W)-1:0]   pending
);

   localparam int unsigned NREG = 1 << ADDR_W;

   logic              hAValid, hBValid;
   logic [ADDR_W-1:0] hAAddr, hBAddr;
   logic [DATA_W-1:0] hAData, hBData;
   logic              grantA, grantB;
   logic              aLoad, bLoad;

`ifdef REGARB_FIXED_PRIO_EN
   always_comb begin
      grantB = hBValid;
      grantA = hAValid & ~hBValid;
   end
`else
   typedef enum logic {PREF_A, PREF_B} rrState_t;
   rrState_t rr;

   always_comb begin
      grantA = hAValid & (~hBValid | (rr == PREF_A));
      grantB = hBValid & (~hAValid | (rr == PREF_B));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    rr <= PREF_A;
      else if (flush)  rr <= PREF_A;
      else if (grantA) rr <= PREF_B;
      else if (grantB) rr <= PREF_A;
   end
`endif

   assign a_ready = ~hAValid | grantA;
   assign b_ready = ~hBValid | grantB;

   // Writes to register 0 complete the handshake but are dropped here.
   assign aLoad = a_valid & a_ready & (a_addr != '0);
   assign bLoad = b_valid & b_ready & (b_addr != '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hAValid <= 1'b0;
         hAAddr  <= '0;
         hAData  <= '0;
      end else if (flush) begin
         hAValid <= 1'b0;
      end else if (aLoad) begin
         hAValid <= 1'b1;
         hAAddr  <= a_addr;
         hAData  <= a_data;
      end else if (grantA) begin
         hAValid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hBValid <= 1'b0;
         hBAddr  <= '0;
         hBData  <= '0;
      end else if (flush) begin
         hBValid <= 1'b0;
      end else if (bLoad) begin
         hBValid <= 1'b1;
         hBAddr  <= b_addr;
         hBData  <= b_data;
      end else if (grantB) begin
         hBValid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (flush) begin
         wr_en <= 1'b0;
      end else if (grantA) begin
         wr_en   <= 1'b1;
         wr_addr <= hAAddr;
         wr_data <= hAData;
      end else if (grantB) begin
         wr_en   <= 1'b1;
         wr_addr <= hBAddr;
         wr_data <= hBData;
      end else begin
         wr_en <= 1'b0;
      end
   end

   always_comb begin
      pending = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         pending[r] = (hAValid & (hAAddr == ADDR_W'(r)))
                    | (hBValid & (hBAddr == ADDR_W'(r)))
                    | (wr_en   & (wr_addr == ADDR_W'(r)));
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register bank between two writeback sources: port A (ALU results) and port B (load data). Each source hands over writes with a valid/ready handshake into a one-entry holding register. A round-robin arbiter drains the holding registers into a registered write stage that drives the bank's `writeAddy`/`writeData`/`cu_writeReg` inputs. The block also publishes a pending-write mask so the control unit can stall reads of registers whose writes are still in flight.

## Interface

Parameters:
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register address width (2^ADDR_W registers).

Ports:
- `clock`, in, 1: the only clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous discard of all queued and staged writes.
- `a_valid`, in, 1: port A write request.
- `a_addr`, in, ADDR_W: port A destination register.
- `a_data`, in, DATA_W: port A write data.
- `a_ready`, out, 1: port A can accept this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same meaning, for port B.
- `wr_en`, out, 1: drives `cu_writeReg` of the bank.
- `wr_addr`, out, ADDR_W: drives `writeAddy`.
- `wr_data`, out, DATA_W: drives `writeData`.
- `pending`, out, 2^ADDR_W: bit r = 1 while a write to register r is held or staged.

## Operation

- State:
  - Holding registers `hA` and `hB`, each with fields valid/addr/data.
  - Round-robin pointer `rr`: 0 means A preferred, 1 means B preferred.
  - Output stage `wr_en`/`wr_addr`/`wr_data`.
- Accept:
  - `a_ready = !hA.valid | grantA`.
  - A handshake (`a_valid & a_ready`) loads `hA` at the edge. Port B is identical.
- Grant (combinational, from holding valids and `rr` only; independent of `*_valid`):
  - One holding register valid → it is granted.
  - Both valid → the port selected by `rr` is granted.
  - None valid → no grant.
- On a grant at an edge:
  - The output stage loads the granted addr/data with `wr_en = 1`.
  - The granted holding register clears, unless a new handshake on that port reloads it at the same edge.
  - `rr` becomes the non-granted port.
- No grant: `wr_en = 0` next cycle; `wr_addr`/`wr_data` hold their last values; `rr` is unchanged.
- Address 0:
  - A handshake with addr 0 is accepted (ready behaves normally) but is not loaded into the holding register.
  - It never reaches the bank and never sets `pending[0]`.
- `pending[r]` is the OR of:
  - `hA.valid & hA.addr==r`,
  - `hB.valid & hB.addr==r`,
  - `wr_en & wr_addr==r`.
  
  `pending[0]` is always 0. The mask is purely combinational from registered state.
- Same address held in both ports: both writes are issued in grant order. The bank keeps the later one.
- `flush` (highest priority among synchronous events):
  - At the edge, `hA.valid`, `hB.valid` and `wr_en` all clear, and `rr` resets to 0.
  - Handshakes in the flush cycle are discarded.
  - `a_ready`/`b_ready` still follow the formula above.

## Timing

- Reset values: `hA.valid = hB.valid = 0`, `rr = 0`, `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`. Consequently `a_ready = b_ready = 1` and `pending = 0`.
- Latency: a handshake at edge N gives `wr_en = 1` in the cycle after edge N+1 at the earliest (uncontended). The bank commits at edge N+2.
- Under contention a request waits at most one extra cycle.
- Throughput: 1 write per cycle aggregate; each port alone sustains 1 per cycle through same-cycle refill.
- `reset_n` asserted mid-operation clears all state immediately, independent of `clock`. Writes in flight are lost.

## Configuration

- `REGARB_FIXED_PRIO_EN`:
  - Defined: `rr` is removed and port B (load) always wins a tie. Port A can starve while B streams.
  - Undefined (default): round-robin as described above.

## Test plan

- Reset, then a single write A (addr 5, data 0x0000_00AA) at edge 1 → `wr_en = 1`, `wr_addr = 5`, `wr_data = 0xAA` after edge 2; `pending[5] = 1` from after edge 1 through the `wr_en` cycle, then 0.
- A (addr 3, 0x11) and B (addr 4, 0x22) accepted at the same edge → A issued first, B next cycle; `rr` toggles. With `REGARB_FIXED_PRIO_EN`: B first, then A.
- A and B both write addr 7 (A = 0x1, B = 0x2) at the same edge, round-robin from reset → issue order A then B; the bank ends at 0x2.
- Back-to-back A writes on every cycle (addrs 1..8) with B idle → `a_ready` stays 1 and `wr_en` stays 1 for 8 consecutive cycles, in order.
- Write to addr 0 with data 0xFFFF_FFFF → accepted, `wr_en` never asserts, `pending = 0`.
- Both holding registers full plus `wr_en = 1`, then `flush` pulse → next cycle `wr_en = 0`, `pending = 0`, both readies = 1; `reset_n` low mid-stream gives the same result immediately.
